// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
//   F3_*         : funct3 encodings of the RV32I load/store access sizes
//   lsu_state_t  : bus-transaction state of the MEM-stage LSU
//   access_err() : misalignment / illegal-funct3 detection for one access
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  // An access is rejected when its funct3 is unused, when a halfword/word
  // is not naturally aligned, or when a store carries an unsigned (1xx) size.
  function automatic logic access_err(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    logic e;
    case (f3)
      F3_B, F3_BU: e = 1'b0;
      F3_H, F3_HU: e = off[0];
      F3_W:        e = (off != 2'b00);
      default:     e = 1'b1;
    endcase
    return e | (is_store & f3[2]);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword out of a 32-bit read word and
// sign- or zero-extends it to 32 bits.
//   rdata  : read word from data memory
//   offset : byte offset of the access within the word
//   funct3 : access size/sign (B, H, W, BU, HU)
//   result : extended load value
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection by the access offset.
  always_comb begin
    byte_s = 8'h00;
    case (offset)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extension according to the access size and signedness.
  always_comb begin
    result = 32'h0000_0000;
    case (funct3)
      F3_B:    result = {{24{byte_s[7]}}, byte_s};
      F3_BU:   result = {24'h00_0000, byte_s};
      F3_H:    result = {{16{half_s[15]}}, half_s};
      F3_HU:   result = {16'h0000, half_s};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: converts the pipeline's load/store controls
// into a req/gnt/rvalid data-memory transaction, stalls IF..MEM while the
// access is outstanding and returns the extended load result.
//   clk, reset                : clock, asynchronous active-low reset
//   MemReadM/MemWriteM        : load / store present in MEM (load wins)
//   funct3M, ALUResultM       : access size/sign and byte address
//   WriteDataM                : store source (rs2)
//   HoldM                     : MEM held by another stall source
//   StallM, AccessErrM        : pipeline stall, suppressed-access flag
//   load_data                 : extended load result
//   dmem_*                    : data-memory bus
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [2:0]      funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic            HoldM,
  output logic            StallM,
  output logic            AccessErrM,
  output logic [XLEN-1:0] load_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  lsu_state_t      state_r;
  lsu_state_t      state_nxt_s;
  logic [1:0]      offset_r;
  logic [2:0]      funct3_r;
  logic            is_load_r;
  logic [XLEN-1:0] load_data_r;

  logic            access_s;
  logic            is_store_s;
  logic            err_s;
  logic            issue_s;
  logic            capture_s;
  logic            req_s;
  logic            stall_s;
  logic            err_out_s;
  logic [XLEN-1:0] ld_s;
  logic [XLEN-1:0] ext_s;
  lsu_state_t      route_s;

  assign access_s   = MemReadM | MemWriteM;
  assign is_store_s = MemWriteM & ~MemReadM;
  assign err_s      = access_err(is_store_s, funct3M, ALUResultM[1:0]);

  // Where a completing access goes: park in DONE while MEM is held.
  assign route_s = HoldM ? DONE : IDLE;

  // Extension works from the held offset/funct3 so it is valid in WAIT.
  load_extend u_load_extend (
    .rdata  (dmem_rdata),
    .offset (offset_r),
    .funct3 (funct3_r),
    .result (ext_s)
  );

  // Transaction FSM: next state, bus request, stall and error flags.
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    stall_s     = 1'b0;
    err_out_s   = 1'b0;
    issue_s     = 1'b0;
    capture_s   = 1'b0;
    ld_s        = load_data_r;
    case (state_r)
      IDLE: begin
        if (access_s && err_s) begin
          err_out_s   = 1'b1;
          state_nxt_s = IDLE;
        end else if (access_s) begin
          req_s   = 1'b1;
          issue_s = 1'b1;
          if (dmem_gnt && MemReadM) begin
            stall_s     = 1'b1;
            state_nxt_s = WAIT;
          end else if (dmem_gnt) begin
            state_nxt_s = route_s;
          end else begin
            stall_s     = 1'b1;
            state_nxt_s = REQ;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        req_s = 1'b1;
        if (dmem_gnt && is_load_r) begin
          stall_s     = 1'b1;
          state_nxt_s = WAIT;
        end else if (dmem_gnt) begin
          state_nxt_s = route_s;
        end else begin
          stall_s     = 1'b1;
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (dmem_rvalid) begin
          ld_s        = ext_s;
          capture_s   = HoldM;
          state_nxt_s = route_s;
        end else begin
          stall_s     = 1'b1;
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        if (HoldM) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Bus formatting; MEM inputs are frozen by StallM so these stay stable in REQ.
  always_comb begin
    dmem_addr = {ALUResultM[XLEN-1:2], 2'b00};
    dmem_we   = is_store_s;
    if (is_store_s) begin
      case (funct3M[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << ALUResultM[1:0];
          dmem_wdata = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          dmem_be    = 4'b0011 << {ALUResultM[1], 1'b0};
          dmem_wdata = {2{WriteDataM[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = WriteDataM;
        end
      endcase
    end else begin
      dmem_be    = 4'b1111;
      dmem_wdata = {XLEN{1'b0}};
    end
  end

  // The FSM settles to IDLE asynchronously, but the combinational IDLE path
  // would still see MEM controls, so the handshake outputs are gated too.
  assign StallM     = stall_s & reset;
  assign dmem_req   = req_s & reset;
  assign AccessErrM = err_out_s & reset;
  assign load_data  = ld_s;

  // State and held access context.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      offset_r    <= 2'b00;
      funct3_r    <= 3'b000;
      is_load_r   <= 1'b0;
      load_data_r <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (issue_s) begin
        offset_r  <= ALUResultM[1:0];
        funct3_r  <= funct3M;
        is_load_r <= MemReadM;
      end
      if (capture_s) begin
        load_data_r <= ext_s;
      end
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
Load/store unit for the MEM stage of the RV32I pipeline. It turns MEM-stage load/store controls into a req/gnt/rvalid data-memory bus transaction. It stalls the pipeline while an access is outstanding. It returns byte-aligned, sign- or zero-extended load_data for capture by the MEM/WB register.

Parameters:
XLEN, 32, datapath and address width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
MemReadM  in  1  load in MEM
MemWriteM  in  1  store in MEM
funct3M  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
ALUResultM  in  32  effective byte address
WriteDataM  in  32  store source (rs2)
HoldM  in  1  MEM held by another stall source
StallM  out  1  access incomplete; freeze IF..MEM
AccessErrM  out  1  misaligned or illegal funct3; access suppressed
load_data  out  32  extended load result, valid when access completes
dmem_req  out  1  bus request
dmem_we  out  1  1=store
dmem_addr  out  32  word address ({addr[31:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid (loads only, 1 cycle)
dmem_rdata  in  32  read word

Behaviour:
- States: IDLE, REQ, WAIT, DONE. On reset: state=IDLE. Held registers (offset, funct3, load_data) = 0. StallM, dmem_req and AccessErrM are forced 0 while reset is asserted.
- Access present = MemReadM|MemWriteM. If both are set, the access is a load (MemWriteM ignored).
- Error check:
  - funct3 011/110/111 is illegal.
  - Halfword with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - Stores also treat funct3 1xx as illegal.
  - On error in IDLE: AccessErrM=1 (combinational), dmem_req=0, StallM=0. The instruction retires as a no-op.
- IDLE, valid access:
  - dmem_req=1 combinationally.
  - addr offset and funct3 are captured into held registers on every issue.
  - gnt=1, store: complete same cycle, StallM=0.
  - gnt=1, load: go to WAIT, StallM=1.
  - gnt=0: go to REQ, StallM=1.
- REQ:
  - dmem_req=1. we/addr/be/wdata stay stable until gnt (MEM inputs are frozen by StallM).
  - On gnt: a store completes; a load goes to WAIT. StallM=1 except in a store's completion cycle.
- WAIT:
  - dmem_req=0, StallM=1 until dmem_rvalid.
  - In the rvalid cycle: StallM=0, load_data = extend(dmem_rdata) combinationally.
- Completion routing: if HoldM=0, go to IDLE. If HoldM=1, go to DONE and register load_data.
- DONE:
  - StallM=0, dmem_req=0.
  - load_data comes from the held register and stays stable.
  - No reissue while HoldM=1. Go to IDLE when HoldM=0.
- load_data in IDLE/REQ is don't-care; it is driven from the held register.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, be=4'b0011<<{addr[1],1'b0}.
  - SW: wdata=rs2, be=4'b1111.
- Loads: dmem_be=4'b1111. The byte/half is selected by the held offset. B/H are sign-extended; BU/HU are zero-extended.
- dmem_rvalid outside WAIT is ignored, including responses to a request issued before reset. dmem_gnt while dmem_req=0 is ignored.
- Latency:
  - Store with immediate gnt: 0 stall cycles.
  - Load with immediate gnt and rvalid next cycle: 1 stall cycle.
  - In general, a load stalls for cycles-to-gnt plus cycles-to-rvalid.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams F3_B/H/W/BU/HU.
  - lsu_state_t enum {IDLE,REQ,WAIT,DONE}.
- One combinational sub-module, load_extend (rdata, offset, funct3 -> 32-bit result), reused by any future load path.

Test Plan:
- Reset assertion: reset=0 during WAIT -> dmem_req=0, StallM=0, load_data=0. Then reset=1, then a stray rvalid with rdata 0xDEADBEEF -> state stays IDLE, no completion.
- SB, addr 0x1003, rs2 0x000000A5, gnt same cycle -> dmem_addr 0x1000, be 4'b1000, wdata 0xA5A5A5A5, we=1, StallM=0 throughout.
- LB, addr 0x2001, gnt after 2 cycles, rvalid 1 cycle later, rdata 0x000080FF -> StallM high 3 cycles, then low with load_data 0xFFFFFF80. Same stimulus as LBU -> 0x00000080.
- LHU, addr 0x2002, rdata 0xBEEF1234 -> load_data 0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- LH at 0x2003, and LW at 0x2002 -> AccessErrM=1, dmem_req=0, StallM=0. funct3 011 load -> same response.
- LW, addr 0x3000, rdata 0x12345678, HoldM=1 at completion -> DONE. load_data holds 0x12345678 for 3 cycles while rdata changes to 0xFFFFFFFF, and dmem_req stays 0. HoldM=0 -> IDLE.
